// File: rtl/vgaconsole_pkg.sv
// vgaconsole_pkg
// Shared definitions for the VGA console TTY write sequencer:
//   - tty_state_t : sequencer FSM states
//   - CODE_* / PRINT_* : recognised control codes and printable range
//   - DEF_* : default geometry and input FIFO depth
package vgaconsole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SCROLL_COPY,
    ST_FILL
  } tty_state_t;

  localparam logic [6:0] CODE_BS   = 7'h08;
  localparam logic [6:0] CODE_LF   = 7'h0A;
  localparam logic [6:0] CODE_FF   = 7'h0C;
  localparam logic [6:0] CODE_CR   = 7'h0D;
  localparam logic [6:0] PRINT_MIN = 7'h20;
  localparam logic [6:0] PRINT_MAX = 7'h7E;

  localparam int DEF_NUM_ROWS   = 3;
  localparam int DEF_NUM_COLS   = 10;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/vgaconsole_char_fifo.sv
// vgaconsole_char_fifo
// Small synchronous FIFO holding host characters until the sequencer is idle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write side (ignored when full)
//   pop, pop_data       : read side; pop_data shows the head combinationally
//   full, empty         : status flags
module vgaconsole_char_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/vgaconsole_tty_ctrl.sv
// vgaconsole_tty_ctrl
// Terminal-style write sequencer for the VGA console text buffer. Host
// characters are queued in a FIFO, interpreted one at a time, and turned
// into text-buffer writes; overflow past the last row scrolls the screen.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid, in_data, in_ready   : host character handshake ({color, code})
//   buf_we, buf_waddr, buf_wdata  : text-buffer write port
//   buf_raddr, buf_rdata          : text-buffer combinational read port (scroll)
//   cursor_row, cursor_col        : current cursor position
//   busy                          : queued work or sequencer not idle
module vgaconsole_tty_ctrl
  import vgaconsole_pkg::*;
#(
  parameter int         NUM_ROWS      = DEF_NUM_ROWS,
  parameter int         NUM_COLS      = DEF_NUM_COLS,
  parameter int         FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter logic [1:0] DEFAULT_COLOR = 2'b00,
  parameter logic [6:0] FILL_CHAR     = 7'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [8:0] in_data,
  output logic       in_ready,
  output logic       buf_we,
  output logic [4:0] buf_waddr,
  output logic [8:0] buf_wdata,
  output logic [4:0] buf_raddr,
  input  logic [8:0] buf_rdata,
  output logic [1:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  localparam logic [4:0] COLS_W    = 5'(NUM_COLS);
  localparam logic [1:0] ROW_LAST  = 2'(NUM_ROWS - 1);
  localparam logic [3:0] COL_LAST  = 4'(NUM_COLS - 1);
  localparam logic [4:0] LAST_COPY = 5'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [4:0] LAST_CELL = 5'(NUM_ROWS * NUM_COLS - 1);

  tty_state_t state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [8:0] cmd_q, cmd_d;
  logic [4:0] idx_q, idx_d;

  logic       fifo_push;
  logic       fifo_pop;
  logic [8:0] fifo_data;
  logic       fifo_full;
  logic       fifo_empty;

  logic [6:0] code;
  logic [4:0] cur_addr;
  logic       do_newline;

  assign fifo_push  = in_valid && in_ready;
  assign in_ready   = !fifo_full;
  assign busy       = !fifo_empty || (state_q != ST_IDLE);
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign code       = cmd_q[6:0];
  assign cur_addr   = 5'(row_q) * COLS_W + 5'(col_q);

  vgaconsole_char_fifo #(
    .WIDTH(9),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cmd_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
    end
  end

  // Scroll and form-feed share one cell index: copy runs up to the start of
  // the last row, and FILL always ends on the last cell, so a scroll simply
  // continues counting from the copy phase into the fill phase.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    fifo_pop   = 1'b0;
    do_newline = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = '0;
    buf_wdata  = '0;
    buf_raddr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_data;
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        if (code >= PRINT_MIN && code <= PRINT_MAX) begin
          buf_we    = 1'b1;
          buf_waddr = cur_addr;
          buf_wdata = cmd_q;
          if (col_q < COL_LAST) begin
            col_d = col_q + 4'd1;
          end else begin
            do_newline = 1'b1;
          end
        end else if (code == CODE_LF) begin
          do_newline = 1'b1;
        end else if (code == CODE_CR) begin
          col_d = '0;
        end else if (code == CODE_BS) begin
          if (col_q != 4'd0) begin
            col_d = col_q - 4'd1;
          end
        end else if (code == CODE_FF) begin
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = ST_FILL;
        end

        if (do_newline) begin
          col_d = '0;
          if (row_q < ROW_LAST) begin
            row_d = row_q + 2'd1;
          end else begin
            idx_d   = '0;
            state_d = ST_SCROLL_COPY;
          end
        end
      end

      ST_SCROLL_COPY: begin
        buf_we    = 1'b1;
        buf_raddr = idx_q + COLS_W;
        buf_waddr = idx_q;
        buf_wdata = buf_rdata;
        idx_d     = idx_q + 5'd1;
        if (idx_q == LAST_COPY) begin
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        buf_we    = 1'b1;
        buf_waddr = idx_q;
        buf_wdata = {DEFAULT_COLOR, FILL_CHAR};
        idx_d     = idx_q + 5'd1;
        if (idx_q == LAST_CELL) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vgaconsole_tty_ctrl.sv
// tb_vgaconsole_tty_ctrl
// Directed bench for the TTY write sequencer. A behavioural text buffer
// answers the read port; an independent screen model predicts every buffer
// write into a scoreboard queue that a negedge monitor drains.
module tb_vgaconsole_tty_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = '0;
  logic       in_ready;
  logic       buf_we;
  logic [4:0] buf_waddr;
  logic [8:0] buf_wdata;
  logic [4:0] buf_raddr;
  logic [8:0] buf_rdata;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  logic [8:0]  tb_mem  [32];
  logic [8:0]  exp_mem [32];
  logic [13:0] exp_q [$];
  int m_row = 0;
  int m_col = 0;
  int errors = 0;
  int checks = 0;
  int we_count = 0;

  localparam logic [8:0] FILL = 9'h020;

  vgaconsole_tty_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .buf_we    (buf_we),
    .buf_waddr (buf_waddr),
    .buf_wdata (buf_wdata),
    .buf_raddr (buf_raddr),
    .buf_rdata (buf_rdata),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Text buffer: synchronous write, combinational read.
  assign buf_rdata = tb_mem[buf_raddr];
  always @(posedge clk) begin
    if (buf_we) tb_mem[buf_waddr] <= buf_wdata;
  end

  // Scoreboard monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    logic [13:0] exp;
    if (rst_n && buf_we) begin
      we_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_write: got waddr=%0d wdata=%h, required no write", buf_waddr, buf_wdata);
      end
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        assert ({buf_waddr, buf_wdata} === exp) else begin
          errors++;
          $error("[TB] FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                 buf_waddr, buf_wdata, exp[13:9], exp[8:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Screen model: predicts writes for one character.
  task automatic modelFill(input int first);
    for (int i = first; i < 30; i++) begin
      exp_q.push_back({5'(i), FILL});
      exp_mem[i] = FILL;
    end
  endtask

  task automatic modelNewline();
    m_col = 0;
    if (m_row < 2) begin
      m_row++;
    end else begin
      for (int i = 0; i < 20; i++) begin
        exp_q.push_back({5'(i), exp_mem[i+10]});
        exp_mem[i] = exp_mem[i+10];
      end
      modelFill(20);
    end
  endtask

  task automatic modelChar(input logic [8:0] d);
    logic [6:0] c;
    int a;
    c = d[6:0];
    if (c >= 7'h20 && c <= 7'h7E) begin
      a = m_row * 10 + m_col;
      exp_q.push_back({5'(a), d});
      exp_mem[a] = d;
      if (m_col < 9) m_col++;
      else modelNewline();
    end else if (c == 7'h0A) begin
      modelNewline();
    end else if (c == 7'h0D) begin
      m_col = 0;
    end else if (c == 7'h08) begin
      if (m_col > 0) m_col--;
    end else if (c == 7'h0C) begin
      m_row = 0;
      m_col = 0;
      modelFill(0);
    end
  endtask

  // Offers one character and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [8:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_timeout", 32'(guard < 500), 32'd1);
    modelChar(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_timeout"}, 32'(n < 1000), 32'd1);
    checkOutput({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkCursor(input string tag, input int r, input int c);
    checkOutput({tag, "_row"}, 32'(cursor_row), 32'(r));
    checkOutput({tag, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  initial begin
    int n;
    int w0;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = {2'b01, 7'(7'h30 + i)};
      exp_mem[i] = {2'b01, 7'(7'h30 + i)};
    end

    // Reset state
    #12;
    checkOutput("rst_buf_we", 32'(buf_we), 32'd0);
    checkOutput("rst_waddr", 32'(buf_waddr), 32'd0);
    checkOutput("rst_wdata", 32'(buf_wdata), 32'd0);
    checkOutput("rst_raddr", 32'(buf_raddr), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkCursor("rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 'A': write strobe in the cycle after the pop edge
    applyStimulus(9'h041);
    checkOutput("A_no_we_before_pop", 32'(buf_we), 32'd0);
    @(posedge clk); #1;
    checkOutput("A_we", 32'(buf_we), 32'd1);
    checkOutput("A_waddr", 32'(buf_waddr), 32'd0);
    checkOutput("A_wdata", 32'(buf_wdata), 32'h041);
    @(posedge clk); #1;
    checkOutput("A_we_drop", 32'(buf_we), 32'd0);
    checkCursor("A", 0, 1);
    waitIdle("A");
    checkOutput("A_busy", 32'(busy), 32'd0);
    checkOutput("A_committed", 32'(tb_mem[0]), 32'h041);

    // Ten printable chars from (0,0) wrap to the next row
    applyStimulus(9'h00D);
    for (int i = 0; i < 10; i++) applyStimulus({2'(i), 7'(7'h61 + i)});
    waitIdle("row0");
    checkCursor("row0", 1, 0);

    // Move to (2,5), then LF triggers scroll
    applyStimulus(9'h00A);
    for (int i = 0; i < 5; i++) applyStimulus({2'b10, 7'(7'h4B + i)});
    waitIdle("pos25");
    checkCursor("pos25", 2, 5);
    w0 = we_count;
    applyStimulus(9'h00A);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("scroll_busy_cycles", 32'(n), 32'd32);
    checkOutput("scroll_write_count", 32'(we_count - w0), 32'd30);
    checkOutput("scroll_queue_drained", 32'(exp_q.size()), 32'd0);
    checkCursor("scroll", 2, 0);
    checkOutput("scroll_bottom_fill", 32'(tb_mem[29]), 32'h020);

    // Control codes: CR, BS at col 0, BS at col 3, unknown code
    applyStimulus(9'h00D);
    waitIdle("cr");
    checkCursor("cr", 2, 0);
    applyStimulus(9'h008);
    waitIdle("bs0");
    checkCursor("bs0", 2, 0);
    for (int i = 0; i < 3; i++) applyStimulus({2'b01, 7'(7'h78 + i)});
    applyStimulus(9'h008);
    waitIdle("bs3");
    checkCursor("bs3", 2, 2);
    applyStimulus(9'h001);
    waitIdle("unk");
    checkCursor("unk", 2, 2);

    // Form feed clears the whole screen
    w0 = we_count;
    applyStimulus(9'h10C);
    waitIdle("ff");
    checkOutput("ff_write_count", 32'(we_count - w0), 32'd30);
    checkCursor("ff", 0, 0);
    checkOutput("ff_cell0", 32'(tb_mem[0]), 32'h020);

    // Queue fills while a scroll is in progress
    applyStimulus(9'h00A);
    applyStimulus(9'h00A);
    waitIdle("pos20");
    checkCursor("pos20", 2, 0);
    applyStimulus(9'h00A);
    for (int i = 0; i < 4; i++) applyStimulus({2'b11, 7'(7'h70 + i)});
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_busy", 32'(busy), 32'd1);
    applyStimulus({2'b11, 7'h74});
    waitIdle("held");
    checkCursor("held", 2, 5);
    checkOutput("held_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a scroll
    applyStimulus(9'h00A);
    repeat (6) @(negedge clk);
    checkOutput("midscroll_we", 32'(buf_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we", 32'(buf_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkCursor("abort", 0, 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    for (int i = 0; i < 32; i++) exp_mem[i] = tb_mem[i];
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus({2'b11, 7'h5A});
    waitIdle("post_rst");
    checkCursor("post_rst", 0, 1);
    checkOutput("post_rst_cell0", 32'(tb_mem[0]), 32'h1DA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
